seq_mul_unit: RTL and testbench

SEQ_MUL_UNIT -- requirements
Module: seq_mul_unit

---
 rtl/seq_mul_unit_if.sv | 31 +++
 rtl/seq_mul_unit.sv | 101 ++++++++++
 tb/tb_seq_mul_unit.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/seq_mul_unit_if.sv
// seq_mul_unit_if
// Handshake and data bundle for the sequential multiplier.
//   start     : request to begin a multiply, sampled on the rising clock edge
//   is_signed : 1 = two's-complement operands, 0 = unsigned (sampled with start)
//   data1     : multiplicand, WIDTH bits (sampled with start)
//   data2     : multiplier, WIDTH bits (sampled with start)
//   busy      : high while an operation is running
//   done      : one-cycle pulse, result valid in the same cycle
//   result    : registered 2*WIDTH-bit product, held until the next completion
// master drives the request side, slave is the multiplier itself.
interface seq_mul_unit_if #(
    parameter int WIDTH = 8
);
    logic                   start;
    logic                   is_signed;
    logic [WIDTH-1:0]       data1;
    logic [WIDTH-1:0]       data2;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     result;

    modport master (
        output start, is_signed, data1, data2,
        input  busy, done, result
    );

    modport slave (
        input  start, is_signed, data1, data2,
        output busy, done, result
    );
endinterface

// File: rtl/seq_mul_unit.sv
// seq_mul_unit
// Shift-and-add multiplier, one multiplier bit per clock, sign handled by
// multiplying magnitudes and negating the product at the end.
// Ports:
//   clk : sole clock, rising edge
//   rst : asynchronous active-high reset
//   bus : seq_mul_unit_if.slave (start/is_signed/data1/data2 in,
//         busy/done/result out)
// Parameter WIDTH: operand width, 2..32.
// Optional macro SEQ_MUL_EARLY_EXIT_EN: leave RUN as soon as the remaining
// multiplier bits are all zero (shorter latency, identical results).
module seq_mul_unit #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    seq_mul_unit_if.slave      bus
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIN  = 2'd2;

    logic [1:0]           state;
    logic [2*WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   result;
    logic [WIDTH-1:0]     mplier;
    logic [CW-1:0]        count;
    logic                 neg;

    logic [WIDTH-1:0]     mag1;
    logic [WIDTH-1:0]     mag2;
    logic                 neg_in;
    logic                 run_exit;

    // Operand magnitudes. Negating the most negative value wraps to
    // 2^(WIDTH-1), which is exactly the right unsigned magnitude.
    always_comb begin
        mag1   = bus.data1;
        mag2   = bus.data2;
        neg_in = 1'b0;
        if (bus.is_signed) begin
            if (bus.data1[WIDTH-1]) mag1 = -bus.data1;
            if (bus.data2[WIDTH-1]) mag2 = -bus.data2;
            neg_in = bus.data1[WIDTH-1] ^ bus.data2[WIDTH-1];
        end
    end

`ifdef SEQ_MUL_EARLY_EXIT_EN
    // Once no multiplier bits remain, further iterations would add nothing.
    assign run_exit = (count == '0) || (mplier == '0);
`else
    assign run_exit = (count == '0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            mcand  <= '0;
            acc    <= '0;
            result <= '0;
            mplier <= '0;
            count  <= '0;
            neg    <= 1'b0;
        end else begin
            case (state)
                // FIN accepts a new request just like IDLE, for back-to-back use.
                IDLE, FIN: begin
                    if (bus.start) begin
                        mcand  <= {{WIDTH{1'b0}}, mag1};
                        mplier <= mag2;
                        neg    <= neg_in;
                        acc    <= '0;
                        count  <= CW'(WIDTH);
                        state  <= RUN;
                    end else begin
                        state  <= IDLE;
                    end
                end
                RUN: begin
                    if (run_exit) begin
                        result <= neg ? -acc : acc;
                        state  <= FIN;
                    end else begin
                        if (mplier[0]) acc <= acc + mcand;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        count  <= count - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy   = (state == RUN);
    assign bus.done   = (state == FIN);
    assign bus.result = result;
endmodule

// File: tb/tb_seq_mul_unit.sv
// tb_seq_mul_unit
// Directed-vector bench for seq_mul_unit at WIDTH=8. Expected products are
// hand-computed constants; latency expectations follow the build (fixed
// WIDTH+1 edges, or bit length of multiplier magnitude + 1 when
// SEQ_MUL_EARLY_EXIT_EN is defined).
module tb_seq_mul_unit;
    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   errors;

    seq_mul_unit_if #(.WIDTH(8)) bus ();

    seq_mul_unit #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock and an edge counter used to measure latency.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Single comparison point: counts every check, reports mismatches.
    task automatic check_output(input string tag, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    // Edges from the START edge to DONE for a given multiplier.
    function automatic int exp_lat(input logic sgn, input logic [7:0] b);
`ifdef SEQ_MUL_EARLY_EXIT_EN
        logic [7:0] m;
        int n;
        m = (sgn && b[7]) ? -b : b;
        n = 0;
        for (int i = 0; i < 8; i++) if (m[i]) n = i + 1;
        return n + 1;
`else
        return 9;
`endif
    endfunction

    // Poll at negedges until done, bounded; at = edge count, -1 on timeout.
    task automatic wait_done(output int at, output logic last_busy);
        at = -1;
        last_busy = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus.done) begin
                at = cyc;
                break;
            end
            last_busy = bus.busy;
            @(negedge clk);
        end
    endtask

    task automatic count_dones(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.done) n++;
        end
    endtask

    // One complete operation: request, latency, product, busy and pulse width.
    task automatic apply_stimulus(input logic sgn, input logic [7:0] a,
                                  input logic [7:0] b, input logic [15:0] exp_res,
                                  input string tag);
        int k;
        int at;
        logic last_busy;
        @(negedge clk);
        bus.start = 1'b1; bus.is_signed = sgn; bus.data1 = a; bus.data2 = b;
        @(negedge clk);
        bus.start = 1'b0;
        k = cyc;
        check_output({tag, "_busy_start"}, {31'd0, bus.busy}, 32'd1);
        wait_done(at, last_busy);
        check_output({tag, "_latency"}, at - k, exp_lat(sgn, b));
        check_output({tag, "_result"}, {16'd0, bus.result}, {16'd0, exp_res});
        check_output({tag, "_busy_at_done"}, {31'd0, bus.busy}, 32'd0);
        check_output({tag, "_busy_before_done"}, {31'd0, last_busy}, 32'd1);
        @(negedge clk);
        check_output({tag, "_done_pulse"}, {31'd0, bus.done}, 32'd0);
    endtask

    initial begin
        int k;
        int at;
        int at2;
        int n;
        logic lb;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.start = 1'b0; bus.is_signed = 1'b0; bus.data1 = '0; bus.data2 = '0;
        repeat (2) @(negedge clk);
        check_output("reset_busy", {31'd0, bus.busy}, 32'd0);
        check_output("reset_done", {31'd0, bus.done}, 32'd0);
        check_output("reset_result", {16'd0, bus.result}, 32'd0);
        rst = 1'b0;

        // Unsigned and signed products, including the most-negative corners.
        apply_stimulus(1'b0, 8'd200, 8'd255, 16'hC738, "u200x255");
        apply_stimulus(1'b0, 8'd255, 8'd255, 16'hFE01, "u255x255");
        apply_stimulus(1'b1, 8'h80, 8'h80, 16'h4000, "s_m128xm128");
        apply_stimulus(1'b1, 8'hFD, 8'd5, 16'hFFF1, "s_m3x5");
        apply_stimulus(1'b1, 8'd127, 8'h80, 16'hC080, "s_127xm128");
        apply_stimulus(1'b1, 8'd5, 8'd7, 16'd35, "s_5x7");
        apply_stimulus(1'b0, 8'd10, 8'd3, 16'd30, "u10x3");
        apply_stimulus(1'b0, 8'd10, 8'd0, 16'd0, "u10x0");

        // START during RUN must not disturb the in-flight 7x6.
        @(negedge clk);
        bus.start = 1'b1; bus.is_signed = 1'b0; bus.data1 = 8'd7; bus.data2 = 8'd6;
        @(negedge clk);
        bus.start = 1'b0;
        k = cyc;
        @(negedge clk);
        bus.start = 1'b1; bus.is_signed = 1'b1; bus.data1 = 8'd9; bus.data2 = 8'd9;
        repeat (2) @(negedge clk);
        bus.start = 1'b0;
        wait_done(at, lb);
        check_output("ignore_latency", at - k, exp_lat(1'b0, 8'd6));
        check_output("ignore_result", {16'd0, bus.result}, 32'd42);
        count_dones(15, n);
        check_output("ignore_no_extra_done", n, 0);

        // Reset after the 4th RUN edge of 15x15 aborts it immediately.
        @(negedge clk);
        bus.start = 1'b1; bus.is_signed = 1'b0; bus.data1 = 8'd15; bus.data2 = 8'd15;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check_output("abort_busy", {31'd0, bus.busy}, 32'd0);
        check_output("abort_done", {31'd0, bus.done}, 32'd0);
        check_output("abort_result", {16'd0, bus.result}, 32'd0);
        #2;
        rst = 1'b0;
        count_dones(15, n);
        check_output("abort_no_done", n, 0);
        apply_stimulus(1'b0, 8'd3, 8'd4, 16'd12, "after_reset_3x4");

        // START held through FIN chains 2x3 straight into 4x5.
        @(negedge clk);
        bus.start = 1'b1; bus.is_signed = 1'b0; bus.data1 = 8'd2; bus.data2 = 8'd3;
        @(negedge clk);
        k = cyc;
        bus.data1 = 8'd4; bus.data2 = 8'd5;
        wait_done(at, lb);
        check_output("b2b_first_latency", at - k, exp_lat(1'b0, 8'd3));
        check_output("b2b_first_result", {16'd0, bus.result}, 32'd6);
        @(negedge clk);
        bus.start = 1'b0;
        check_output("b2b_restart_busy", {31'd0, bus.busy}, 32'd1);
        wait_done(at2, lb);
        check_output("b2b_gap", at2 - at, exp_lat(1'b0, 8'd5) + 1);
        check_output("b2b_second_result", {16'd0, bus.result}, 32'd20);
        @(negedge clk);
        check_output("b2b_idle", {30'd0, bus.busy, bus.done}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
